// File: rtl/wm8731_cfg_seq.sv
// wm8731_cfg_seq: power-up configuration sequencer for the WM8731 codec.
// Waits a settle time after a setup request, then writes eight codec
// registers through I2C_Controller using the GO/END handshake and ACK check.
// Optional feature macro: WM_CFG_RETRY_EN (per-register retries on failure).
module wm8731_cfg_seq #(
  parameter logic [7:0] SLAVE_ADDR     = 8'h34,
  parameter int         SETTLE_CYCLES  = 2000,
  parameter int         TIMEOUT_CYCLES = 1023,
  parameter int         RETRY_MAX      = 3
) (
  input  logic        clock_20Khz,
  input  logic        pin_reset,
  input  logic        pin_setup,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [2:0]  cfg_index
);

  // One down/up counter serves the settle wait, the END timeout and the gap.
  localparam int CNT_MAX_A = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > RETRY_MAX) ? CNT_MAX_A : RETRY_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // Codec register words, written in order; the activate write must be last.
  localparam logic [15:0] REG_TABLE [8] = '{
    16'h1E00, 16'h0C07, 16'h0E13, 16'h1001,
    16'h0579, 16'h0812, 16'h0A00, 16'h13FF
  };

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_LOAD, S_GO, S_WAIT, S_GAP, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         idx_reg, idx_next;
  logic               fail_reg, fail_next;
  logic [23:0]        data_reg, data_next;
  logic               go_reg, go_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic [2:0]         sync_reg;
  logic               start_req;

`ifdef WM_CFG_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RW-1:0]      retry_reg, retry_next;
`endif

  // Two-flop synchronizer plus one edge-detect stage for the setup button.
  always_ff @(posedge clock_20Khz or negedge pin_reset) begin
    if (!pin_reset) sync_reg <= 3'b111;
    else            sync_reg <= {sync_reg[1:0], pin_setup};
  end

  assign start_req = sync_reg[2] & ~sync_reg[1];

  // State and datapath registers; async reset forces GO low immediately.
  always_ff @(posedge clock_20Khz or negedge pin_reset) begin
    if (!pin_reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      fail_reg  <= 1'b0;
      data_reg  <= 24'h0;
      go_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
`ifdef WM_CFG_RETRY_EN
      retry_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      fail_reg  <= fail_next;
      data_reg  <= data_next;
      go_reg    <= go_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
`ifdef WM_CFG_RETRY_EN
      retry_reg <= retry_next;
`endif
    end
  end

  // Next-state and register-update logic for the write sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    fail_next  = fail_reg;
    data_next  = data_reg;
    go_next    = go_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    error_next = error_reg;
`ifdef WM_CFG_RETRY_EN
    retry_next = retry_reg;
`endif
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_req) begin
          state_next = S_SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          idx_next   = 3'd0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          error_next = 1'b0;
`ifdef WM_CFG_RETRY_EN
          retry_next = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_reg == '0) state_next = S_LOAD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_LOAD: begin
        // Data is registered a full cycle ahead of GO.
        data_next  = {SLAVE_ADDR, REG_TABLE[idx_reg]};
        state_next = S_GO;
      end
      S_GO: begin
        go_next    = 1'b1;
        cnt_next   = '0;
        fail_next  = 1'b0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_end) begin
          fail_next  = i2c_ack;
          go_next    = 1'b0;
          cnt_next   = '0;
          state_next = S_GAP;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
          fail_next  = 1'b1;
          go_next    = 1'b0;
          cnt_next   = '0;
          state_next = S_GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        // Leave only after two low-GO cycles and once the controller drops END.
        if (cnt_reg != '0 && !i2c_end) state_next = S_CHECK;
        else                          cnt_next   = CNT_W'(1);
      end
      S_CHECK: begin
        if (!fail_reg) begin
          if (idx_reg == 3'd7) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = S_LOAD;
`ifdef WM_CFG_RETRY_EN
            retry_next = '0;
`endif
          end
        end else begin
`ifdef WM_CFG_RETRY_EN
          if (retry_reg < RW'(RETRY_MAX)) begin
            retry_next = retry_reg + 1'b1;
            state_next = S_LOAD;
          end else begin
            state_next = S_ERROR;
            error_next = 1'b1;
            busy_next  = 1'b0;
          end
`else
          state_next = S_ERROR;
          error_next = 1'b1;
          busy_next  = 1'b0;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign i2c_data  = data_reg;
  assign i2c_go    = go_reg;
  assign cfg_busy  = busy_reg;
  assign cfg_done  = done_reg;
  assign cfg_error = error_reg;
  assign cfg_index = idx_reg;

endmodule

// File: doc/wm8731_cfg_seq.md
# wm8731_cfg_seq

Codec configuration sequencer on the `clock_20Khz` domain. It sits directly upstream of `I2C_Controller` and replaces the inline setup loop in the audio top level. On a setup request, it waits a power-up settle time, then issues a fixed table of eight WM8731 register writes as 24-bit `{slave, reg/data}` words. Each write uses a GO/END handshake and checks ACK. The block reports ready or error to the top level, which drives the ready LED and gates playback.

## Interface
Parameters:
- `SLAVE_ADDR`, default 8'h34: I2C write address placed in bits [23:16] of every word.
- `SETTLE_CYCLES`, default 2000: clock cycles waited after a start request before the first write (100 ms at 20 kHz). Must be ≥1.
- `TIMEOUT_CYCLES`, default 1023: maximum cycles spent waiting for `i2c_end` before the write is treated as NACK.
- `RETRY_MAX`, default 3: additional attempts per register (only used with `WM_CFG_RETRY_EN`).

Ports:
- `clock_20Khz`  in  1  sequencer clock, the same clock that drives `I2C_Controller`.
- `pin_reset`  in  1  asynchronous, active-low reset.
- `pin_setup`  in  1  active-low setup push-button, asynchronous to this clock.
- `i2c_end`  in  1  END from `I2C_Controller`; high means the transfer is finished.
- `i2c_ack`  in  1  ACK from `I2C_Controller`; 1 means a NACK was seen, valid while `i2c_end` is high.
- `i2c_data`  out  24  word to transfer: `{SLAVE_ADDR, table[idx]}`.
- `i2c_go`  out  1  GO to `I2C_Controller`.
- `cfg_busy`  out  1  a sequence is in progress.
- `cfg_done`  out  1  all eight writes were acknowledged; drives `pin_led_ready`.
- `cfg_error`  out  1  the sequence was aborted on a NACK or timeout.
- `cfg_index`  out  3  index of the current or failing table entry.

## Operation
- `pin_setup` passes through a 2-flop synchronizer. A falling edge of the synchronized signal is the start request.
- Start requests are accepted only in IDLE, DONE and ERROR; requests in any other state are ignored.
- Register table, fixed, indices 0 to 7: 16'h1E00 (reset), 16'h0C07, 16'h0E13, 16'h1001, 16'h0579, 16'h0812, 16'h0A00, 16'h13FF (activate last).
- State machine:
  - IDLE/DONE/ERROR on start request → SETTLE: load the counter, clear `cfg_done` and `cfg_error`, set `idx=0`, set `cfg_busy=1`.
  - SETTLE: count down `SETTLE_CYCLES`, then → LOAD.
  - LOAD: register `i2c_data`, then → GO.
  - GO: assert `i2c_go`, clear the timeout counter, then → WAIT.
  - WAIT: when `i2c_end`=1, capture `i2c_ack`, deassert `i2c_go`, then → GAP. When the timeout counter reaches `TIMEOUT_CYCLES`, deassert `i2c_go` and mark a failure, then → GAP.
  - GAP: hold `i2c_go`=0 for at least 2 cycles and until `i2c_end`=0, then → CHECK.
  - CHECK:
    - On success with `idx`=7 → DONE.
    - On success otherwise, increment `idx` → LOAD.
    - On failure → retry or ERROR (see Configuration).
  - DONE: `cfg_done=1`, `cfg_busy=0`.
  - ERROR: `cfg_error=1`, `cfg_busy=0`, and `cfg_index` holds the failing entry.
- `cfg_done` and `cfg_error` are never high together.

## Timing
- Reset values of all outputs are 0: `i2c_data`=24'h0, `i2c_go`, `cfg_busy`, `cfg_done`, `cfg_error`, `cfg_index`. State resets to IDLE.
- Start latency: `cfg_busy` rises on the 3rd rising edge after `pin_setup` falls (2 synchronizer stages plus 1 edge-detect stage).
- `i2c_data` is stable for at least 1 cycle before `i2c_go` rises, and stays unchanged until `i2c_go` falls.
- `i2c_go` falls on the edge after the cycle in which `i2c_end` is sampled high.
- Minimum time per register is 5 cycles plus the controller transfer time.
- If `pin_reset` is asserted mid-transfer, `i2c_go` drops to 0 immediately and the block returns to IDLE. The controller is reset by the same pin.
- `i2c_end` high while in SETTLE or LOAD is ignored.

## Configuration
- `WM_CFG_RETRY_EN` defined:
  - A failure in CHECK with fewer than `RETRY_MAX` retries used for the current entry increments the retry counter and goes to LOAD with the same `idx`.
  - The retry counter clears whenever `idx` advances.
  - Exhausting the retries → ERROR.
- `WM_CFG_RETRY_EN` undefined: the first failure → ERROR. No retry counter is synthesized.

## Test plan
- Reset with the `I2C_Controller` model always returning END after 30 cycles with ack=0, then pulse `pin_setup` low → eight writes in table order, each `i2c_data`=24'h34xxxx, ending with `cfg_done`=1, `cfg_busy`=0, `cfg_index`=7.
- Model NACKs (ack=1) entry 3 once → retry build: entry 3 is sent twice, then `cfg_done`=1. Non-retry build: `cfg_error`=1, `cfg_index`=3, no write for entry 4.
- Model never raises END at entry 0 → after `TIMEOUT_CYCLES` (1023) plus the GAP state, the block shows `cfg_error`=1 with `i2c_go`=0. In the retry build this happens after 4 attempts.
- Pulse `pin_setup` during WAIT → ignored, sequence unchanged. A second pulse after DONE → `cfg_done` clears within 3 cycles and the full sequence reruns.
- Assert `pin_reset` while `i2c_go`=1 at entry 5 → all outputs are 0 immediately, and the next start request restarts from entry 0.
- Check that `i2c_data` is stable from 1 cycle before `i2c_go` rises until `i2c_go` falls, and that `i2c_go` stays low for at least 2 cycles between writes.
